add_seq_ctrl: RTL and testbench
===============================

ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001 Parameter: CHUNKS, default 2, number of 16-bit slices per operand; legal range 1..4; operand width W = 16*CHUNKS.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-004 start  input  1  request a new addition; accepted only when ready is high.
REQ-005 a  input  W  operand A, sampled on the accepted-start edge.
REQ-006 b  input  W  operand B, sampled on the accepted-start edge.
REQ-007 cin  input  1  carry into bit 0, sampled on the accepted-start edge.
REQ-008 ready  output  1  high in IDLE and DONE; start accepted only when high.
REQ-009 busy  output  1  high in RUN.
REQ-010 done  output  1  one-cycle pulse; sum/cout valid.
REQ-011 sum  output  W  result a+b+cin modulo 2^W.
REQ-012 cout  output  1  carry out of bit W-1.
REQ-013 ovf  output  1  signed overflow; present only when ADD_SEQ_OVF_EN is defined.

Function
REQ-014 The block SHALL contain exactly one instance of the team 16-bit carry-lookahead adder (ports A, B, cin, cout, S); no other adder logic on the datapath.
REQ-015 FSM states SHALL be IDLE, RUN, DONE; encoding left to implementer.
REQ-016 IDLE: start=1 -> latch a, b, cin into operand/carry registers, clear chunk index, go RUN; start=0 -> stay IDLE.
REQ-017 RUN: each cycle feed slice [16*idx+15:16*idx] of latched A and B plus carry register to the adder; write S into same slice of sum, write adder cout into carry register, increment idx.
REQ-018 RUN -> DONE on the cycle idx = CHUNKS-1 is processed; otherwise remain RUN.
REQ-019 DONE: done=1 for exactly that cycle; cout output = carry register; start=1 -> latch new operands, go RUN (back-to-back); else go IDLE.
REQ-020 Latency: start accepted at edge T -> done high in cycle T+CHUNKS+1; throughput one result per CHUNKS+1 cycles.
REQ-021 start while busy=1 SHALL be ignored; a, b, cin changes during RUN SHALL not affect the result.
REQ-022 sum, cout (and ovf) SHALL hold their last DONE values in IDLE until the first RUN cycle of the next operation; only done qualifies them.
REQ-023 Carry SHALL propagate across slice boundaries exactly as a W-bit add; slice 0 uses latched cin.
REQ-024 ready = (state==IDLE || state==DONE); busy = (state==RUN); both mutually exclusive.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force IDLE, idx=0, carry register=0, sum=0, cout=0, done=0, busy=0, ready=1, ovf=0 if present.
REQ-026 Reset asserted mid-RUN SHALL abandon the operation with no done pulse; first cycle after release is IDLE.
REQ-027 start sampled in the same edge as rst_n=0 SHALL be ignored.

Configuration
REQ-028 Macro ADD_SEQ_OVF_EN defined: ovf port present; on the final slice ovf register <= (A[W-1]==B[W-1]) && (S[15]!=A[W-1]); valid with done, held like sum.
REQ-029 Macro ADD_SEQ_OVF_EN undefined: ovf port and its logic absent; all other behaviour identical.

Verification (CHUNKS=2 unless stated)
REQ-030 a=0xFFFFFFFF, b=0x00000001, cin=0, start at T -> done at T+3, sum=0x00000000, cout=1, ovf=0.
REQ-031 a=0x0000FFFF, b=0x00000000, cin=1 -> sum=0x00010000, cout=0 (cross-slice carry).
REQ-032 ADD_SEQ_OVF_EN defined: a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, ovf=1, cout=0.
REQ-033 start pulsed and operands changed during RUN -> ignored, original result delivered; start held high in DONE -> next operation begins, done cycles spaced exactly 3 apart.
REQ-034 rst_n=0 during first RUN cycle -> no done, sum=0, ready=1 on next cycle.
REQ-035 CHUNKS=1 and CHUNKS=4: 1000 random a, b, cin -> {cout,sum} equals a+b+cin, done at T+CHUNKS+1.

Source files
------------

// File: rtl/add_seq_ctrl.sv
// Multi-cycle W-bit adder: one shared 16-bit CLA slice walks the operands LSB first.
// Optional signed-overflow output is enabled by defining ADD_SEQ_OVF_EN.

module cla16 (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        cin,
  output logic        cout,
  output logic [15:0] S
);

  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [15:0] w_c;
  logic [3:0]  w_gg;
  logic [3:0]  w_pp;
  logic [4:0]  w_bc;
  logic [4:0]  w_t;

  // Carries c[4:0] of a 4-bit lookahead group from generate/propagate and carry-in
  function automatic logic [4:0] cla4(input logic [3:0] g, input logic [3:0] p, input logic c0);
    logic [4:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  // Two-level lookahead: group G/P, group carries, then in-group carries
  always_comb begin
    w_g  = A & B;
    w_p  = A ^ B;
    w_gg = '0;
    w_pp = '0;
    w_c  = '0;
    w_t  = '0;
    for (int k = 0; k < 4; k++) begin
      w_t     = cla4(w_g[4*k +: 4], w_p[4*k +: 4], 1'b0);
      w_gg[k] = w_t[4];
      w_pp[k] = &w_p[4*k +: 4];
    end
    w_bc = cla4(w_gg, w_pp, cin);
    for (int k = 0; k < 4; k++) begin
      w_t            = cla4(w_g[4*k +: 4], w_p[4*k +: 4], w_bc[k]);
      w_c[4*k +: 4]  = w_t[3:0];
    end
  end

  assign S    = w_p ^ w_c;
  assign cout = w_bc[4];

endmodule

module add_seq_ctrl #(
  parameter int unsigned CHUNKS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [16*CHUNKS-1:0]  a,
  input  logic [16*CHUNKS-1:0]  b,
  input  logic                  cin,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [16*CHUNKS-1:0]  sum,
  output logic                  cout
`ifdef ADD_SEQ_OVF_EN
  ,
  output logic                  ovf
`endif
);

  localparam int unsigned W     = 16 * CHUNKS;
  localparam int unsigned IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;
  logic             w_ready_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic [W-1:0]     r_sum;
  logic             r_cout;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;

  logic [15:0]      w_a_sl;
  logic [15:0]      w_b_sl;
  logic [15:0]      w_s;
  logic             w_co;

  cla16 u_cla (
    .A    (w_a_sl),
    .B    (w_b_sl),
    .cin  (r_carry),
    .cout (w_co),
    .S    (w_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= w_ready_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next state; status flags are registered from the next state so they align with it
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_idx == LAST_IDX) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_ready_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE);
    w_busy_nxt  = (w_state_nxt == S_RUN);
    w_done_nxt  = (w_state_nxt == S_DONE);
  end

  always_comb begin
    w_a_sl = '0;
    w_b_sl = '0;
    for (int i = 0; i < int'(CHUNKS); i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_a_sl = r_a[16*i +: 16];
        w_b_sl = r_b[16*i +: 16];
      end
    end
  end

  // Results are only written during RUN, so they hold through DONE and IDLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      r_carry <= w_co;
      r_idx   <= r_idx + IDX_W'(1);
      for (int i = 0; i < int'(CHUNKS); i++) begin
        if (r_idx == IDX_W'(i)) begin
          r_sum[16*i +: 16] <= w_s;
        end
      end
      if (w_last) begin
        r_cout <= w_co;
      end
    end
  end

`ifdef ADD_SEQ_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if ((r_state == S_RUN) && w_last) begin
      r_ovf <= (r_a[W-1] == r_b[W-1]) && (w_s[15] != r_a[W-1]);
    end
  end

  assign ovf = r_ovf;
`endif

  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;
  assign sum   = r_sum;
  assign cout  = r_cout;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl at CHUNKS = 1, 2 and 4 sharing one clock and reset.
// Overflow checks are included when ADD_SEQ_OVF_EN is defined.

module tb_add_seq_ctrl;

  logic        clk;
  logic        rst_n;

  logic        s1, s2, s4;
  logic [15:0] a1, b1;
  logic [31:0] a2, b2;
  logic [63:0] a4, b4;
  logic        c1, c2, c4;

  logic        rdy1, bsy1, dn1, co1;
  logic        rdy2, bsy2, dn2, co2;
  logic        rdy4, bsy4, dn4, co4;
  logic [15:0] sum1;
  logic [31:0] sum2;
  logic [63:0] sum4;
  logic        ov1, ov2, ov4;

  int          sel;
  logic [63:0] o_sum;
  logic        o_done, o_rdy, o_bsy, o_co, o_ov;

  int          n_cmp;
  int          n_err;

  add_seq_ctrl #(.CHUNKS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .a(a1), .b(b1), .cin(c1),
    .ready(rdy1), .busy(bsy1), .done(dn1), .sum(sum1), .cout(co1)
`ifdef ADD_SEQ_OVF_EN
    , .ovf(ov1)
`endif
  );

  add_seq_ctrl #(.CHUNKS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(s2), .a(a2), .b(b2), .cin(c2),
    .ready(rdy2), .busy(bsy2), .done(dn2), .sum(sum2), .cout(co2)
`ifdef ADD_SEQ_OVF_EN
    , .ovf(ov2)
`endif
  );

  add_seq_ctrl #(.CHUNKS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4), .cin(c4),
    .ready(rdy4), .busy(bsy4), .done(dn4), .sum(sum4), .cout(co4)
`ifdef ADD_SEQ_OVF_EN
    , .ovf(ov4)
`endif
  );

`ifndef ADD_SEQ_OVF_EN
  assign ov1 = 1'b0;
  assign ov2 = 1'b0;
  assign ov4 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    o_sum  = '0;
    o_done = 1'b0;
    o_rdy  = 1'b0;
    o_bsy  = 1'b0;
    o_co   = 1'b0;
    o_ov   = 1'b0;
    case (sel)
      1: begin o_sum = 64'(sum1); o_done = dn1; o_rdy = rdy1; o_bsy = bsy1; o_co = co1; o_ov = ov1; end
      2: begin o_sum = 64'(sum2); o_done = dn2; o_rdy = rdy2; o_bsy = bsy2; o_co = co2; o_ov = ov2; end
      4: begin o_sum = sum4;      o_done = dn4; o_rdy = rdy4; o_bsy = bsy4; o_co = co4; o_ov = ov4; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic [63:0] va, input logic [63:0] vb,
                       input logic vc, input logic st);
    s1 = 1'b0; s2 = 1'b0; s4 = 1'b0;
    case (w)
      1: begin a1 = va[15:0]; b1 = vb[15:0]; c1 = vc; s1 = st; end
      2: begin a2 = va[31:0]; b2 = vb[31:0]; c2 = vc; s2 = st; end
      4: begin a4 = va;       b4 = vb;       c4 = vc; s4 = st; end
      default: ;
    endcase
  endtask

  // One full operation; operands are scrambled right after acceptance
  task automatic do_op(input int w, input logic [63:0] va, input logic [63:0] vb, input logic vc,
                       input logic [63:0] es, input logic ec, input logic eo, input string tag);
    int k;
    @(negedge clk);
    sel = w;
    drive(w, va, vb, vc, 1'b1);
    @(negedge clk);
    drive(w, ~va, ~vb, ~vc, 1'b0);
    k = 0;
    while (!o_done && k < 16) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, 64'(k), 64'(w));
    chk({tag, "_sum"}, o_sum, es);
    chk({tag, "_cout"}, 64'(o_co), 64'(ec));
`ifdef ADD_SEQ_OVF_EN
    chk({tag, "_ovf"}, 64'(o_ov), 64'(eo));
`endif
    chk({tag, "_rdy_bsy"}, {62'd0, o_rdy, o_bsy}, 64'b10);
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(o_done), 64'd0);
    chk({tag, "_hold"}, o_sum, es);
  endtask

  initial begin
    logic [63:0] va, vb, es, msk;
    logic [64:0] full;
    logic        vc, ec, eo;
    int          msb;
    bit          saw_done;

    n_cmp = 0; n_err = 0; sel = 2;
    rst_n = 1'b0;
    s1 = 1'b0; s2 = 1'b1; s4 = 1'b0;
    a1 = '0; b1 = '0; c1 = 1'b0;
    a2 = 32'h1234_5678; b2 = 32'h1111_1111; c2 = 1'b1;
    a4 = '0; b4 = '0; c4 = 1'b0;

    // Reset with start held high: start must be ignored
    repeat (2) @(negedge clk);
    chk("rst_flags", {61'd0, o_rdy, o_bsy, o_done}, 64'b100);
    chk("rst_sum", o_sum, 64'd0);
    chk("rst_cout_ovf", {62'd0, o_co, o_ov}, 64'd0);
    rst_n = 1'b1;
    s2 = 1'b0;
    @(negedge clk);
    chk("rst_start_ignored", {62'd0, o_rdy, o_bsy}, 64'b10);

    // CHUNKS=2 directed vectors
    do_op(2, 64'hFFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, "c2_wrap");
    do_op(2, 64'h0000_FFFF, 64'h0, 1'b1, 64'h0001_0000, 1'b0, 1'b0, "c2_xslice");
    do_op(2, 64'h7FFF_FFFF, 64'h1, 1'b0, 64'h8000_0000, 1'b0, 1'b1, "c2_posovf");
    do_op(2, 64'h8000_0000, 64'h8000_0000, 1'b0, 64'h0, 1'b1, 1'b1, "c2_negovf");
    do_op(2, 64'h1234_5678, 64'h9ABC_DEF0, 1'b1, 64'hACF1_3569, 1'b0, 1'b0, "c2_mixed");
    do_op(2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF, 1'b1, 1'b0, "c2_allones");

    // Start/operand changes during RUN ignored, then back-to-back from DONE
    @(negedge clk);
    sel = 2;
    drive(2, 64'h1111_1111, 64'h2222_2222, 1'b0, 1'b1);
    @(negedge clk);
    chk("b2b_busy", {62'd0, o_rdy, o_bsy}, 64'b01);
    drive(2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, 1'b1);
    @(negedge clk);
    chk("b2b_run2_nodone", 64'(o_done), 64'd0);
    @(negedge clk);
    chk("b2b_first_done", 64'(o_done), 64'd1);
    chk("b2b_first_sum", {31'd0, o_co, o_sum[31:0]}, {31'd0, 1'b0, 32'h3333_3333});
    @(negedge clk);
    drive(2, 64'h0, 64'h0, 1'b0, 1'b0);
    chk("b2b_rerun", {61'd0, o_rdy, o_bsy, o_done}, 64'b010);
    @(negedge clk);
    chk("b2b_gap", 64'(o_done), 64'd0);
    @(negedge clk);
    chk("b2b_second_done", 64'(o_done), 64'd1);
    chk("b2b_second_sum", {31'd0, o_co, o_sum[31:0]}, {31'd0, 1'b1, 32'hFFFF_FFFE});
    @(negedge clk);
    chk("b2b_idle_hold", {29'd0, o_rdy, o_done, o_co, o_sum[31:0]}, {29'd0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE});

    // Reset during the first RUN cycle abandons the operation
    drive(2, 64'h0000_FFFF, 64'h1, 1'b0, 1'b1);
    @(negedge clk);
    drive(2, 64'h0, 64'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_flags", {61'd0, o_rdy, o_bsy, o_done}, 64'b100);
    chk("midrst_sum", {31'd0, o_co, o_sum[31:0]}, 64'd0);
    saw_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (o_done) saw_done = 1'b1;
    end
    chk("midrst_no_done", 64'(saw_done), 64'd0);

    // CHUNKS=1 directed vectors
    do_op(1, 64'hFFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, "c1_wrap");
    do_op(1, 64'h7FFF, 64'h0, 1'b1, 64'h8000, 1'b0, 1'b1, "c1_ovf");
    do_op(1, 64'h1234, 64'h4321, 1'b0, 64'h5555, 1'b0, 1'b0, "c1_plain");

    // CHUNKS=4 directed vectors
    do_op(4, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0, "c4_wrap");
    do_op(4, 64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 1'b0, "c4_ripple");
    do_op(4, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0,
          64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, "c4_ovf");
    do_op(4, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0,
          64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, "c4_comp");

    // Random operands against a wide-add reference for CHUNKS=1 and 4
    for (int r = 0; r < 20; r++) begin
      int w;
      w   = (r % 2 == 0) ? 1 : 4;
      msb = 16 * w - 1;
      msk = (w == 4) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_0000_FFFF;
      va  = {$urandom, $urandom} & msk;
      vb  = {$urandom, $urandom} & msk;
      vc  = 1'($urandom);
      full = {1'b0, va} + {1'b0, vb} + 65'(vc);
      es  = full[63:0] & msk;
      ec  = (w == 4) ? full[64] : full[16];
      eo  = (va[msb] == vb[msb]) && (es[msb] != va[msb]);
      do_op(w, va, vb, vc, es, ec, eo, (w == 4) ? "c4_rand" : "c1_rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
